// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared FSM state type and sizing helpers for the SRAM arbiter
package sram_arb_pkg;

   typedef enum logic [2:0] {IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD, DONE} state_e;

   localparam int WAIT_CYCLES_DEF = 1;
   localparam int DATA_W_DEF      = 32;
   localparam int WAIT_W          = $clog2(WAIT_CYCLES_DEF + 2);
   localparam int BE_W            = DATA_W_DEF / 8;

   function automatic int wait_w(input int wait_cycles);
      return $clog2(wait_cycles + 2);
   endfunction

   function automatic int be_w(input int data_w);
      return data_w / 8;
   endfunction

   function automatic int idx_w(input int num_ch);
      return (num_ch > 1) ? $clog2(num_ch) : 1;
   endfunction

endpackage

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if: requester-side bundle (packed per-channel requests, shared read data)
interface sram_arbiter_if #(
   parameter int NUM_CH = 2,
   parameter int ADDR_W = 20,
   parameter int DATA_W = 32
);

   logic [NUM_CH-1:0]          req;
   logic [NUM_CH-1:0]          we;
   logic [NUM_CH*ADDR_W-1:0]   addr;
   logic [NUM_CH*DATA_W-1:0]   wdata;
   logic [NUM_CH*DATA_W/8-1:0] be_n;
   logic [NUM_CH-1:0]          ack;
   logic [DATA_W-1:0]          rdata;

   modport master (output req, we, addr, wdata, be_n, input ack, rdata);
   modport slave  (input req, we, addr, wdata, be_n, output ack, rdata);

endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin request picker; SRAM_ARB_FIXED_PRIO_EN makes channel 0 highest fixed priority
module rr_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_CH = 2,
   localparam int IDX_W = idx_w(NUM_CH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] req_i,
   input  logic              en_i,
   output logic [NUM_CH-1:0] gnt_o,
   output logic [IDX_W-1:0]  idx_o,
   output logic              valid_o
);

   logic [IDX_W-1:0] ptr_q;
   int               c;

`ifdef SRAM_ARB_FIXED_PRIO_EN
   logic unused_rr_inputs;
   assign unused_rr_inputs = ^{clk, rst, en_i};
   assign ptr_q = '0;
`else
   // search start moves to the channel after each accepted grant
   always_ff @(posedge clk or posedge rst)
      if (rst) ptr_q <= '0;
      else if (en_i) ptr_q <= (int'(idx_o) == NUM_CH - 1) ? '0 : idx_o + 1'b1;
`endif

   // scan downward from the farthest offset so the nearest requester after ptr wins
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      c       = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         c = int'(ptr_q) + i;
         c = (c >= NUM_CH) ? c - NUM_CH : c;
         if (req_i[IDX_W'(c)]) begin
            idx_o   = IDX_W'(c);
            valid_o = 1'b1;
         end
      end
   end

   assign gnt_o = valid_o ? NUM_CH'(1) << idx_o : '0;

endmodule

// File: rtl/sram_arbiter.sv
// sram_arbiter: multi-channel async SRAM controller; define SRAM_ARB_FIXED_PRIO_EN for fixed priority
module sram_arbiter
   import sram_arb_pkg::*;
#(
   parameter int NUM_CH      = 2,
   parameter int ADDR_W      = 20,
   parameter int DATA_W      = 32,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   sram_arbiter_if.slave         bus,
   output logic [ADDR_W-1:0]     ram_addr_o,
   inout  wire  [DATA_W-1:0]     ram_data_io,
   output logic [DATA_W/8-1:0]   ram_be_n_o,
   output logic                  ram_ce_n_o,
   output logic                  ram_oe_n_o,
   output logic                  ram_we_n_o
);

   localparam int CNT_W = wait_w(WAIT_CYCLES);
   localparam int BYTES = be_w(DATA_W);
   localparam int IDX_W = idx_w(NUM_CH);

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   wait_q, wait_d;
   logic [NUM_CH-1:0]  gnt_oh, gnt_oh_q, ack_q;
   logic [IDX_W-1:0]   gnt_idx;
   logic               gnt_valid, gnt_en, last_beat;
   logic [ADDR_W-1:0]  addr_q;
   logic [DATA_W-1:0]  wdata_q, rdata_q;
   logic [BYTES-1:0]   be_n_q;
   logic               ce_n_q, oe_n_q, we_n_q, drv_q;

   rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
      .clk     (clk),
      .rst     (rst),
      .req_i   (bus.req),
      .en_i    (gnt_en),
      .gnt_o   (gnt_oh),
      .idx_o   (gnt_idx),
      .valid_o (gnt_valid)
   );

   assign gnt_en    = (state_q == IDLE) && gnt_valid;
   assign last_beat = wait_q == CNT_W'(WAIT_CYCLES);

   // state and strobe-length counter
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q <= IDLE;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end

   // next state: strobe phases last WAIT_CYCLES+1 cycles, writes get setup and hold around WE
   always_comb begin
      state_d = state_q;
      wait_d  = '0;
      case (state_q)
         IDLE:     state_d = gnt_valid ? (bus.we[gnt_idx] ? WR_SETUP : RD) : IDLE;
         RD:       begin
                      state_d = last_beat ? DONE : RD;
                      wait_d  = last_beat ? '0 : wait_q + 1'b1;
                   end
         WR_SETUP: state_d = WR_PULSE;
         WR_PULSE: begin
                      state_d = last_beat ? WR_HOLD : WR_PULSE;
                      wait_d  = last_beat ? '0 : wait_q + 1'b1;
                   end
         WR_HOLD:  state_d = DONE;
         DONE:     state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   // winner's request fields are frozen at grant; byte enables park inactive after completion
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         addr_q   <= '0;
         wdata_q  <= '0;
         be_n_q   <= '1;
         gnt_oh_q <= '0;
      end else if (gnt_en) begin
         addr_q   <= bus.addr[gnt_idx*ADDR_W +: ADDR_W];
         wdata_q  <= bus.wdata[gnt_idx*DATA_W +: DATA_W];
         be_n_q   <= bus.be_n[gnt_idx*BYTES +: BYTES];
         gnt_oh_q <= gnt_oh;
      end else if (state_q == DONE) begin
         be_n_q   <= '1;
      end

   // pad strobes registered from the next state so they are glitch-free and clear on async reset
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ce_n_q <= 1'b1;
         oe_n_q <= 1'b1;
         we_n_q <= 1'b1;
         drv_q  <= 1'b0;
         ack_q  <= '0;
      end else begin
         ce_n_q <= state_d inside {IDLE, DONE};
         oe_n_q <= state_d != RD;
         we_n_q <= state_d != WR_PULSE;
         drv_q  <= state_d inside {WR_SETUP, WR_PULSE, WR_HOLD};
         ack_q  <= (state_d == DONE) ? gnt_oh_q : '0;
      end

   // read data sampled on the last OE cycle and held until the next read
   always_ff @(posedge clk or posedge rst)
      if (rst) rdata_q <= '0;
      else if (state_q == RD && last_beat) rdata_q <= ram_data_io;

   assign ram_data_io = drv_q ? wdata_q : 'z;
   assign ram_addr_o  = addr_q;
   assign ram_be_n_o  = be_n_q;
   assign ram_ce_n_o  = ce_n_q;
   assign ram_oe_n_o  = oe_n_q;
   assign ram_we_n_o  = we_n_q;
   assign bus.ack     = ack_q;
   assign bus.rdata   = rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed checks of reads, writes, arbitration and async reset against a behavioural SRAM
module tb_sram_arbiter;
   import sram_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [19:0] ram_addr;
   wire  [31:0] ram_data;
   logic [3:0]  ram_be_n;
   logic        ce_n, oe_n, we_n;
   logic [31:0] mem [0:255];
   int          total = 0;
   int          bad = 0;
   int          n, oe_low, we_low, drv_cnt, data_err, oe_conf;
   logic [1:0]  a, acc;
   logic [1:0]  exp_seq [5];

   sram_arbiter_if #(.NUM_CH(2), .ADDR_W(20), .DATA_W(32)) bus ();

   sram_arbiter #(.NUM_CH(2), .ADDR_W(20), .DATA_W(32), .WAIT_CYCLES(1)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .ram_addr_o  (ram_addr),
      .ram_data_io (ram_data),
      .ram_be_n_o  (ram_be_n),
      .ram_ce_n_o  (ce_n),
      .ram_oe_n_o  (oe_n),
      .ram_we_n_o  (we_n)
   );

   always #5 clk = ~clk;

   assign ram_data = (!ce_n && !oe_n) ? mem[ram_addr[7:0]] : 'z;

   always @(posedge clk)
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'(i);
         mem[8'h10] <= 32'hDEADBEEF;
         mem[8'h20] <= 32'hAABBCCDD;
      end else if (!ce_n && !we_n) begin
         for (int b = 0; b < 4; b++)
            if (!ram_be_n[b]) mem[ram_addr[7:0]][b*8 +: 8] <= ram_data[b*8 +: 8];
      end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_ack(output int cnt, output logic [1:0] ack);
      cnt = 0;
      ack = 2'b00;
      while (ack == 2'b00 && cnt < 20) begin
         tick();
         cnt++;
         ack = bus.ack;
         oe_low   += int'(!oe_n);
         we_low   += int'(!we_n);
         drv_cnt  += int'(dut.drv_q);
         data_err += int'(dut.drv_q && ram_data !== 32'h12345678);
         oe_conf  += int'(dut.drv_q && !oe_n);
      end
   endtask

   task automatic clr_counts;
      oe_low = 0; we_low = 0; drv_cnt = 0; data_err = 0; oe_conf = 0;
   endtask

   initial begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
      exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`else
      exp_seq = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`endif
      bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0; bus.be_n = '1;
      tick(); tick();
      rst = 1'b0;
      tick();
      chk("rst_ce_n", 32'(ce_n), 1);
      chk("rst_oe_n", 32'(oe_n), 1);
      chk("rst_we_n", 32'(we_n), 1);
      chk("rst_ack", 32'(bus.ack), 0);
      chk("rst_rdata", bus.rdata, 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_be_n", 32'(ram_be_n), 32'hF);
      chk("rst_bus_drv", 32'(dut.drv_q), 0);

      // ch0 read of 0x10
      clr_counts();
      bus.req[0] = 1'b1; bus.we[0] = 1'b0; bus.addr[19:0] = 20'h00010; bus.be_n[3:0] = 4'h0;
      wait_ack(n, a);
      bus.req[0] = 1'b0;
      chk("rd_latency", n, 3);
      chk("rd_ack", 32'(a), 32'b01);
      chk("rd_oe_cycles", oe_low, 2);
      chk("rd_data", bus.rdata, 32'hDEADBEEF);
      tick();
      chk("rd_ack_pulse", 32'(bus.ack), 0);

      // ch1 partial write to 0x20
      clr_counts();
      bus.req[1] = 1'b1; bus.we[1] = 1'b1; bus.addr[39:20] = 20'h00020;
      bus.wdata[63:32] = 32'h12345678; bus.be_n[7:4] = 4'b1100;
      wait_ack(n, a);
      bus.req[1] = 1'b0;
      chk("wr_latency", n, 5);
      chk("wr_ack", 32'(a), 32'b10);
      chk("wr_we_cycles", we_low, 2);
      chk("wr_drv_cycles", drv_cnt, 4);
      chk("wr_bus_data", data_err, 0);
      chk("wr_oe_conflict", oe_conf + oe_low, 0);
      chk("wr_rdata_kept", bus.rdata, 32'hDEADBEEF);
      tick();

      // ch0 reads back 0x20: only low 16 bits changed
      bus.req[0] = 1'b1; bus.addr[19:0] = 20'h00020;
      wait_ack(n, a);
      bus.req[0] = 1'b0;
      chk("rb_ack", 32'(a), 32'b01);
      chk("rb_data", bus.rdata, 32'hAABB5678);
      tick();
      chk("rb_ack_pulse", 32'(bus.ack), 0);

      // both channels read continuously
      bus.addr[19:0] = 20'h00010; bus.we[1] = 1'b0;
      bus.req = 2'b11;
      for (int k = 0; k < 5; k++) begin
         wait_ack(n, a);
         if (k == 3) bus.req[0] = 1'b0;
         chk($sformatf("arb_ack%0d", k), 32'(a), 32'(exp_seq[k]));
         chk($sformatf("arb_lat%0d", k), n, (k == 0) ? 3 : 4);
         chk($sformatf("arb_data%0d", k), bus.rdata, (a == 2'b01) ? 32'hDEADBEEF : 32'hAABB5678);
      end
      bus.req = 2'b00;
      tick();

      // async reset during the write pulse
      bus.req[0] = 1'b1; bus.we[0] = 1'b1; bus.addr[19:0] = 20'h00030;
      bus.wdata[31:0] = 32'h55AA55AA; bus.be_n[3:0] = 4'h0;
      n = 0;
      while (we_n && n < 10) begin
         tick();
         n++;
      end
      chk("rr_pulse_reached", 32'(we_n), 0);
      #2 rst = 1'b1;
      #1;
      chk("rr_we_n", 32'(we_n), 1);
      chk("rr_ce_n", 32'(ce_n), 1);
      chk("rr_bus_drv", 32'(dut.drv_q), 0);
      chk("rr_ack", 32'(bus.ack), 0);
      bus.req = 2'b00;
      tick();
      rst = 1'b0;
      acc = 2'b00;
      for (int k = 0; k < 4; k++) begin
         tick();
         acc |= bus.ack;
      end
      chk("rr_no_ack", 32'(acc), 0);
      chk("rr_state_idle", 32'(dut.state_q), 32'(IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
